icache_refill: RTL and testbench
================================

Name: icache_refill

Overview:
- Miss-side refill engine for the 2-way instruction cache.
- Accepts the fetch stage's miss (IF_miss/IF_addr), selects a victim way from the set's LRU bit, and issues one AXI4 read burst for the line.
- Writes each returned 64-bit beat into the cache data array, then marks the tag valid.
- Sits between the fetch-stage cache arrays and the AXI read channel.

Parameters:
- N, 2, ways per set (only 2 supported)
- B, 64, block size in bytes
- S, 64, number of sets
- s, 6, set index bits
- b, 3, block offset bits (beats per line = 2^b = B/8)
- y, 3, byte offset bits
- t, 52, tag bits (64-s-b-y)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- miss_req  in  1  IF_miss level from fetch, held until the line is valid
- miss_addr  in  64  IF_addr of the missing instruction
- lru_in  in  1  LRU bit of miss set (1 = way 1 is victim)
- flush  in  1  pipeline redirect; cancels install of the current fill
- busy  out  1  refill in progress
- fill_we  out  1  data beat write strobe
- fill_set  out  s  set index
- fill_way  out  1  victim way
- fill_beat  out  b  beat index within line
- fill_data  out  64  beat data
- tag_we  out  1  Valid_Tag write strobe
- tag_wdata  out  t+1  {valid, tag}
- refill_err  out  1  one-cycle pulse on error response
- m_arvalid  out  1  AXI AR valid
- m_arready  in  1  AXI AR ready
- m_araddr  out  64  line-aligned address
- m_arlen  out  8  2^b-1
- m_arsize  out  3  3'b011 (8 bytes)
- m_arburst  out  2  2'b01 INCR (see optional feature)
- m_rvalid  in  1  AXI R valid
- m_rready  out  1  AXI R ready
- m_rdata  in  64  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset. On reset: state IDLE; all strobes, m_arvalid, m_rready, busy and refill_err are 0; address, set, way and beat registers are 0.
- IDLE:
  - If miss_req & !flush: latch set, tag and line address = {miss_addr[63:b+y], 0}; latch way = lru_in.
  - In the same cycle, drive tag_we=1 with tag_wdata={0, tag} to invalidate the victim before any data is overwritten.
  - Go to AR.
- AR: m_arvalid=1 with address/len/size/burst held stable until m_arready; on handshake go to R.
- R:
  - m_rready=1.
  - Each rvalid beat: fill_we=1, fill_data=m_rdata, fill_beat = beat counter (starts at 0, increments per beat, wraps mod 2^b).
  - Any rresp != 0 sets a sticky error flag.
  - A beat with rlast goes to DONE.
  - If rlast arrives before 2^b beats, or the counter wraps without rlast, set the error flag.
- DONE (1 cycle):
  - If no error and no flush seen since accept: tag_we=1, tag_wdata={1, tag}.
  - Otherwise the tag stays invalid and refill_err pulses when the error flag is set.
  - Go to IDLE.
  - The DONE cycle is the turnaround, so the fetch lookup sees the hit and drops miss_req before IDLE samples again.
- busy=1 in AR, R and DONE.
- flush during AR or R sets a sticky cancel. The AXI burst is always completed (no abort); data beats are still written, but the line is never validated.
- flush in DONE also suppresses validation.
- Latched set/way/tag are unaffected by miss_addr changes after accept.
- Reset mid-burst returns to IDLE immediately. The interconnect must be reset in the same cycle; outstanding beats are not tracked.
- Latency, miss_req to valid tag (arready and rvalid always high): 1 cycle AR + 2^b data cycles + 1 DONE, i.e. 10 cycles for B=64.

Optional Feature:
- Macro: ICACHE_CRIT_WORD_FIRST_EN.
- Enabled:
  - m_araddr = {miss_addr[63:y], 0}, m_arburst = WRAP (2'b10).
  - Beat counter starts at miss_addr[b+y-1:y] and wraps mod 2^b.
  - Additional output crit_valid (1 bit) pulses on the first beat, with fill_data being the requested doubleword.
- Disabled: INCR burst from the line-aligned address; crit_valid absent.

Decomposition:
- Package icache_pkg holds:
  - the AXI burst/size/resp constants (BURST_INCR, BURST_WRAP, SIZE_8B, RESP_OKAY);
  - the refill state enum (IDLE, AR, R, DONE);
  - the geometry localparams.
- No sub-module needed. The beat counter and error/cancel flags live inline.

Test Plan:
- Miss at 0x0000_1040 with lru_in=1, arready and rvalid always high: invalidate write to set 1 way 1 at cycle 0; 8 fill_we with beats 0..7; tag_we={1, 0x1} at cycle 10; busy drops the following cycle.
- arready held low 5 cycles: m_arvalid and m_araddr=0x1040 stable throughout; fill begins only after the handshake.
- rresp=2'b10 on beat 3: all 8 beats written, no valid tag write in DONE, refill_err single pulse.
- flush asserted during beat 2: burst drains all 8 beats, valid never set, next miss_req accepted in IDLE.
- rvalid toggling every other cycle: fill_beat strictly 0..7, no duplicate or missed beat; rlast on beat 7 ends the fill.
- With ICACHE_CRIT_WORD_FIRST_EN, miss at 0x1068: m_araddr=0x1068, WRAP burst, beats 5,6,7,0..4, crit_valid on the first beat.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry, AXI read-channel constants and refill state encoding for the
// instruction-cache refill engine.
package icache_pkg;

    localparam int N_WAYS    = 2;
    localparam int BLK_BYTES = 64;
    localparam int N_SETS    = 64;
    localparam int BYTE_W    = 3;
    localparam int SET_W     = $clog2(N_SETS);
    localparam int OFF_W     = $clog2(BLK_BYTES / 8);
    localparam int TAG_W     = 64 - SET_W - OFF_W - BYTE_W;
    localparam int BEATS     = 1 << OFF_W;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef logic [$clog2(N_WAYS)-1:0] way_t;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } refill_state_e;

    function automatic logic [63:0] line_addr(input logic [63:0] addr);
        return {addr[63:OFF_W+BYTE_W], {(OFF_W + BYTE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// AXI4 read address/data channel bundle between the refill engine (master)
// and the memory interconnect (slave).
interface icache_refill_if;

    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid;
    logic        m_rready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
    );

endinterface

// File: rtl/icache_refill.sv
// Instruction-cache miss refill engine: one AXI read burst per missing line.
// Build option ICACHE_CRIT_WORD_FIRST_EN selects a critical-word-first WRAP burst.
//
// state | meaning
// IDLE  | waiting for a miss; invalidates the victim tag on accept
// AR    | read address presented until accepted
// R     | collecting beats into the data array
// DONE  | validate tag (or report error), turnaround for fetch
module icache_refill
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               miss_req,
    input  logic [63:0]        miss_addr,
    input  logic               lru_in,
    input  logic               flush,
    output logic               busy,
    output logic               fill_we,
    output logic [SET_W-1:0]   fill_set,
    output logic               fill_way,
    output logic [OFF_W-1:0]   fill_beat,
    output logic [63:0]        fill_data,
    output logic               tag_we,
    output logic [TAG_W:0]     tag_wdata,
    output logic               refill_err,
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    output logic               crit_valid,
`endif
    icache_refill_if.master    axi
);

    localparam logic [OFF_W-1:0] LAST_CNT = '1;

    refill_state_e      state_q;
    logic [SET_W-1:0]   set_q;
    way_t               way_q;
    logic [TAG_W-1:0]   tag_q;
    logic [63:0]        araddr_q;
    logic [OFF_W-1:0]   beat_q;
    logic [OFF_W-1:0]   cnt_q;
    logic               err_q;
    logic               cancel_q;
    logic               arvalid_q;
    logic               rready_q;
    logic               busy_q;

    logic               accept;
    logic               beat_fire;
    logic               beat_err;
    logic [63:0]        araddr_d;
    logic [OFF_W-1:0]   beat_start_d;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[OFF_W+BYTE_W-1:0];

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    assign araddr_d      = {miss_addr[63:BYTE_W], {BYTE_W{1'b0}}};
    assign beat_start_d  = miss_addr[OFF_W+BYTE_W-1:BYTE_W];
    assign axi.m_arburst = BURST_WRAP;
`else
    assign araddr_d      = line_addr(miss_addr);
    assign beat_start_d  = '0;
    assign axi.m_arburst = BURST_INCR;
`endif

    assign accept    = (state_q == IDLE) && miss_req && !flush && !reset;
    assign beat_fire = (state_q == R) && axi.m_rvalid && rready_q && !reset;
    // Bad response, rlast before the final beat, or the final beat without rlast.
    assign beat_err  = (axi.m_rresp != RESP_OKAY) || (axi.m_rlast != (cnt_q == LAST_CNT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            set_q     <= '0;
            way_q     <= '0;
            tag_q     <= '0;
            araddr_q  <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            cancel_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        set_q     <= miss_addr[SET_W+OFF_W+BYTE_W-1:OFF_W+BYTE_W];
                        tag_q     <= miss_addr[63:SET_W+OFF_W+BYTE_W];
                        way_q     <= lru_in;
                        araddr_q  <= araddr_d;
                        beat_q    <= beat_start_d;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        cancel_q  <= 1'b0;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= AR;
                    end
                end
                AR: begin
                    if (flush) cancel_q <= 1'b1;
                    if (axi.m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= R;
                    end
                end
                R: begin
                    if (flush) cancel_q <= 1'b1;
                    if (beat_fire) begin
                        beat_q <= beat_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        if (beat_err) err_q <= 1'b1;
                        if (axi.m_rlast) begin
                            rready_q <= 1'b0;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.m_arvalid = arvalid_q;
    assign axi.m_araddr  = araddr_q;
    assign axi.m_arlen   = 8'(BEATS - 1);
    assign axi.m_arsize  = SIZE_8B;
    assign axi.m_rready  = rready_q;

    assign busy      = busy_q;
    assign fill_we   = beat_fire;
    assign fill_beat = beat_q;
    assign fill_data = axi.m_rdata;
    // In IDLE the set/way come straight from the miss so the invalidate lands on the victim.
    assign fill_set  = (state_q == IDLE) ? miss_addr[SET_W+OFF_W+BYTE_W-1:OFF_W+BYTE_W] : set_q;
    assign fill_way  = (state_q == IDLE) ? lru_in : way_q;

    assign tag_we     = accept ||
                        (!reset && (state_q == DONE) && !err_q && !cancel_q && !flush);
    assign tag_wdata  = (state_q == DONE) ? {1'b1, tag_q}
                                          : {1'b0, miss_addr[63:SET_W+OFF_W+BYTE_W]};
    assign refill_err = !reset && (state_q == DONE) && err_q;

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    assign crit_valid = beat_fire && (cnt_q == '0);
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed self-checking bench for the instruction-cache refill engine.
module tb_icache_refill;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_req;
    logic [63:0] miss_addr;
    logic        lru_in;
    logic        flush;
    logic        busy;
    logic        fill_we;
    logic [5:0]  fill_set;
    logic        fill_way;
    logic [2:0]  fill_beat;
    logic [63:0] fill_data;
    logic        tag_we;
    logic [52:0] tag_wdata;
    logic        refill_err;
`ifdef ICACHE_CRIT_WORD_FIRST_EN
    logic        crit_valid;
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    int checks = 0;
    int errors = 0;

    icache_refill_if axi ();

    icache_refill dut (
        .clk        (clk),
        .reset      (reset),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .lru_in     (lru_in),
        .flush      (flush),
        .busy       (busy),
        .fill_we    (fill_we),
        .fill_set   (fill_set),
        .fill_way   (fill_way),
        .fill_beat  (fill_beat),
        .fill_data  (fill_data),
        .tag_we     (tag_we),
        .tag_wdata  (tag_wdata),
        .refill_err (refill_err),
`ifdef ICACHE_CRIT_WORD_FIRST_EN
        .crit_valid (crit_valid),
`endif
        .axi        (axi.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; miss_req = 1'b1; miss_addr = 64'h1040; lru_in = 1'b1; flush = 1'b0;
        axi.m_arready = 1'b0; axi.m_rvalid = 1'b0; axi.m_rdata = '0; axi.m_rresp = '0; axi.m_rlast = 1'b0;
        tick(); tick();
        #4;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (axi.m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %b exp 0", axi.m_arvalid); end
        checks++; if (axi.m_rready !== 1'b0) begin errors++; $display("FAIL reset_rready got %b exp 0", axi.m_rready); end
        checks++; if (tag_we !== 1'b0) begin errors++; $display("FAIL reset_tag_we got %b exp 0", tag_we); end
        checks++; if (fill_we !== 1'b0) begin errors++; $display("FAIL reset_fill_we got %b exp 0", fill_we); end
        checks++; if (refill_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", refill_err); end
        checks++; if (axi.m_araddr !== 64'h0) begin errors++; $display("FAIL reset_araddr got %h exp 0", axi.m_araddr); end
        tick();
        reset = 1'b0; miss_req = 1'b0;
        #4;
        checks++; if (busy !== 1'b0 || tag_we !== 1'b0) begin errors++; $display("FAIL reset_release got busy=%b we=%b exp 0 0", busy, tag_we); end
        tick();
    endtask

    task automatic test_miss_basic();
        int sent = 0;
        axi.m_arready = 1'b1; axi.m_rvalid = 1'b1; axi.m_rresp = 2'b00;
        miss_addr = 64'h1040; lru_in = 1'b1; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 11) miss_req = 1'b0;
            axi.m_rdata = 64'hA5A5_0000_0000_0000 | 64'(sent);
            axi.m_rlast = (sent == 7);
            #4;
            if (c == 0) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b0, 52'h1}) begin errors++; $display("FAIL basic_inval got we=%b data=%h exp 1 %h", tag_we, tag_wdata, {1'b0, 52'h1}); end
                checks++; if (fill_set !== 6'd1 || fill_way !== 1'b1) begin errors++; $display("FAIL basic_inval_loc got set=%0d way=%b exp 1 1", fill_set, fill_way); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy0 got %b exp 0", busy); end
            end else if (c == 1) begin
                checks++; if (axi.m_arvalid !== 1'b1 || axi.m_araddr !== 64'h1040) begin errors++; $display("FAIL basic_ar got v=%b a=%h exp 1 1040", axi.m_arvalid, axi.m_araddr); end
                checks++; if (axi.m_arlen !== 8'd7 || axi.m_arsize !== 3'b011 || axi.m_arburst !== EXP_BURST) begin errors++; $display("FAIL basic_arattr got len=%0d size=%b burst=%b", axi.m_arlen, axi.m_arsize, axi.m_arburst); end
                checks++; if (busy !== 1'b1 || fill_we !== 1'b0) begin errors++; $display("FAIL basic_ar_state got busy=%b we=%b exp 1 0", busy, fill_we); end
            end else if (c <= 9) begin
                checks++; if (fill_we !== 1'b1 || fill_beat !== 3'(c - 2)) begin errors++; $display("FAIL basic_beat got we=%b beat=%0d exp 1 %0d", fill_we, fill_beat, c - 2); end
                checks++; if (fill_data !== (64'hA5A5_0000_0000_0000 | 64'(c - 2)) || fill_set !== 6'd1 || fill_way !== 1'b1) begin errors++; $display("FAIL basic_data got %h set=%0d way=%b", fill_data, fill_set, fill_way); end
            end else if (c == 10) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b1, 52'h1}) begin errors++; $display("FAIL basic_valid got we=%b data=%h exp 1 %h", tag_we, tag_wdata, {1'b1, 52'h1}); end
                checks++; if (busy !== 1'b1 || refill_err !== 1'b0 || fill_we !== 1'b0) begin errors++; $display("FAIL basic_done got busy=%b err=%b we=%b", busy, refill_err, fill_we); end
            end else begin
                checks++; if (busy !== 1'b0 || tag_we !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b we=%b exp 0 0", busy, tag_we); end
            end
            if (axi.m_rvalid && axi.m_rready) sent++;
            tick();
        end
        checks++; if (sent !== 8) begin errors++; $display("FAIL basic_beats got %0d exp 8", sent); end
    endtask

    task automatic test_ar_stall();
        int sent = 0;
        axi.m_rvalid = 1'b1; axi.m_rresp = 2'b00;
        miss_addr = 64'h1040; lru_in = 1'b0; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 17; c++) begin
            axi.m_arready = (c >= 6);
            if (c == 1) begin miss_addr = 64'hFFFF_FFFF_FFFF_F000; lru_in = 1'b1; end
            if (c == 16) miss_req = 1'b0;
            axi.m_rdata = 64'h5A00 + 64'(sent);
            axi.m_rlast = (sent == 7);
            #4;
            if (c >= 1 && c <= 6) begin
                checks++; if (axi.m_arvalid !== 1'b1 || axi.m_araddr !== 64'h1040) begin errors++; $display("FAIL stall_ar c=%0d got v=%b a=%h exp 1 1040", c, axi.m_arvalid, axi.m_araddr); end
                checks++; if (fill_we !== 1'b0) begin errors++; $display("FAIL stall_early_fill c=%0d got %b exp 0", c, fill_we); end
            end else if (c >= 7 && c <= 14) begin
                checks++; if (fill_we !== 1'b1 || fill_beat !== 3'(c - 7) || fill_set !== 6'd1 || fill_way !== 1'b0) begin errors++; $display("FAIL stall_beat c=%0d got we=%b beat=%0d set=%0d way=%b", c, fill_we, fill_beat, fill_set, fill_way); end
            end else if (c == 15) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b1, 52'h1}) begin errors++; $display("FAIL stall_valid got we=%b data=%h exp 1 %h", tag_we, tag_wdata, {1'b1, 52'h1}); end
            end else if (c == 16) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", busy); end
            end
            if (axi.m_rvalid && axi.m_rready) sent++;
            tick();
        end
    endtask

    task automatic test_rresp_err();
        int sent = 0;
        int writes = 0;
        int pulses = 0;
        axi.m_arready = 1'b1; axi.m_rvalid = 1'b1;
        miss_addr = 64'h2080; lru_in = 1'b1; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 11) miss_req = 1'b0;
            axi.m_rdata = 64'(sent);
            axi.m_rlast = (sent == 7);
            axi.m_rresp = (sent == 3) ? 2'b10 : 2'b00;
            #4;
            if (fill_we === 1'b1) writes++;
            if (refill_err === 1'b1) pulses++;
            if (c == 10) begin
                checks++; if (tag_we !== 1'b0) begin errors++; $display("FAIL err_no_valid got %b exp 0", tag_we); end
                checks++; if (refill_err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b exp 1", refill_err); end
            end
            if (axi.m_rvalid && axi.m_rready) sent++;
            tick();
        end
        axi.m_rresp = 2'b00;
        checks++; if (writes !== 8) begin errors++; $display("FAIL err_writes got %0d exp 8", writes); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL err_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_early_rlast();
        int sent = 0;
        axi.m_arready = 1'b1; axi.m_rvalid = 1'b1; axi.m_rresp = 2'b00;
        miss_addr = 64'h5000; lru_in = 1'b0; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c == 9) miss_req = 1'b0;
            axi.m_rdata = 64'(sent);
            axi.m_rlast = (sent == 5);
            #4;
            if (c == 8) begin
                checks++; if (tag_we !== 1'b0 || refill_err !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL early_done got we=%b err=%b busy=%b exp 0 1 1", tag_we, refill_err, busy); end
            end else if (c == 9) begin
                checks++; if (busy !== 1'b0 || refill_err !== 1'b0) begin errors++; $display("FAIL early_idle got busy=%b err=%b exp 0 0", busy, refill_err); end
            end
            if (axi.m_rvalid && axi.m_rready) sent++;
            tick();
        end
    endtask

    task automatic test_flush();
        int sent = 0;
        int writes = 0;
        axi.m_arready = 1'b1; axi.m_rvalid = 1'b1; axi.m_rresp = 2'b00;
        miss_addr = 64'h3040; lru_in = 1'b0; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 23; c++) begin
            flush = (c == 4);
            if (c == 22) miss_req = 1'b0;
            axi.m_rdata = 64'(sent);
            axi.m_rlast = (sent == 7);
            #4;
            if (c <= 9 && fill_we === 1'b1) writes++;
            if (c == 10) begin
                checks++; if (tag_we !== 1'b0 || refill_err !== 1'b0) begin errors++; $display("FAIL flush_done got we=%b err=%b exp 0 0", tag_we, refill_err); end
                checks++; if (writes !== 8) begin errors++; $display("FAIL flush_drain got %0d exp 8", writes); end
            end else if (c == 11) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b0, 52'h3} || busy !== 1'b0) begin errors++; $display("FAIL flush_reaccept got we=%b data=%h busy=%b", tag_we, tag_wdata, busy); end
            end else if (c == 21) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b1, 52'h3}) begin errors++; $display("FAIL flush_second_valid got we=%b data=%h exp 1 %h", tag_we, tag_wdata, {1'b1, 52'h3}); end
            end else if (c == 22) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle got %b exp 0", busy); end
            end
            if (axi.m_rvalid && axi.m_rready) sent = (sent + 1) % 8;
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_rvalid_toggle();
        int sent = 0;
        logic exp_we;
        axi.m_arready = 1'b1; axi.m_rresp = 2'b00;
        miss_addr = 64'h4000; lru_in = 1'b0; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 19; c++) begin
            if (c == 18) miss_req = 1'b0;
            axi.m_rvalid = ((c % 2) == 0);
            axi.m_rdata = 64'hC0DE_0000 + 64'(sent);
            axi.m_rlast = axi.m_rvalid && (sent == 7);
            #4;
            exp_we = (c >= 2) && (c <= 16) && ((c % 2) == 0);
            if (c >= 2 && c <= 16) begin
                checks++; if (fill_we !== exp_we) begin errors++; $display("FAIL toggle_we c=%0d got %b exp %b", c, fill_we, exp_we); end
                if (exp_we) begin
                    checks++; if (fill_beat !== 3'((c - 2) / 2) || fill_data !== (64'hC0DE_0000 + 64'((c - 2) / 2))) begin errors++; $display("FAIL toggle_beat c=%0d got beat=%0d data=%h exp %0d", c, fill_beat, fill_data, (c - 2) / 2); end
                end
            end else if (c == 17) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b1, 52'h4}) begin errors++; $display("FAIL toggle_valid got we=%b data=%h exp 1 %h", tag_we, tag_wdata, {1'b1, 52'h4}); end
            end else if (c == 18) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_idle got %b exp 0", busy); end
            end
            if (axi.m_rvalid && axi.m_rready) sent++;
            tick();
        end
        axi.m_rvalid = 1'b1;
    endtask

    task automatic test_reset_mid();
        axi.m_arready = 1'b1; axi.m_rvalid = 1'b1; axi.m_rresp = 2'b00; axi.m_rlast = 1'b0;
        miss_addr = 64'h6000; lru_in = 1'b1; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) reset = 1'b1;
            if (c == 5) begin reset = 1'b0; miss_req = 1'b0; end
            #4;
            if (c == 3) begin
                checks++; if (fill_we !== 1'b1 || fill_beat !== 3'd1) begin errors++; $display("FAIL rstmid_pre got we=%b beat=%0d exp 1 1", fill_we, fill_beat); end
            end else if (c == 4) begin
                checks++; if (fill_we !== 1'b0 || tag_we !== 1'b0) begin errors++; $display("FAIL rstmid_gate got we=%b twe=%b exp 0 0", fill_we, tag_we); end
            end else if (c == 5) begin
                checks++; if (busy !== 1'b0 || axi.m_rready !== 1'b0 || axi.m_arvalid !== 1'b0 || fill_we !== 1'b0) begin errors++; $display("FAIL rstmid_idle got busy=%b rr=%b arv=%b we=%b exp 0 0 0 0", busy, axi.m_rready, axi.m_arvalid, fill_we); end
            end
            tick();
        end
    endtask

`ifdef ICACHE_CRIT_WORD_FIRST_EN
    task automatic test_crit_word();
        int sent = 0;
        logic [2:0] exp_beat;
        axi.m_arready = 1'b1; axi.m_rvalid = 1'b1; axi.m_rresp = 2'b00;
        miss_addr = 64'h1068; lru_in = 1'b0; miss_req = 1'b1; flush = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c == 11) miss_req = 1'b0;
            axi.m_rdata = 64'(sent);
            axi.m_rlast = (sent == 7);
            #4;
            if (c == 1) begin
                checks++; if (axi.m_araddr !== 64'h1068 || axi.m_arburst !== 2'b10) begin errors++; $display("FAIL cwf_ar got a=%h burst=%b exp 1068 10", axi.m_araddr, axi.m_arburst); end
            end else if (c >= 2 && c <= 9) begin
                exp_beat = 3'(5 + c - 2);
                checks++; if (fill_we !== 1'b1 || fill_beat !== exp_beat) begin errors++; $display("FAIL cwf_beat c=%0d got %0d exp %0d", c, fill_beat, exp_beat); end
                checks++; if (crit_valid !== (c == 2)) begin errors++; $display("FAIL cwf_crit c=%0d got %b exp %b", c, crit_valid, (c == 2)); end
            end else if (c == 10) begin
                checks++; if (tag_we !== 1'b1 || tag_wdata !== {1'b1, 52'h1}) begin errors++; $display("FAIL cwf_valid got we=%b data=%h", tag_we, tag_wdata); end
            end
            if (axi.m_rvalid && axi.m_rready) sent++;
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_miss_basic();
        test_ar_stall();
        test_rresp_err();
        test_early_rlast();
        test_flush();
        test_rvalid_toggle();
        test_reset_mid();
`ifdef ICACHE_CRIT_WORD_FIRST_EN
        test_crit_word();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
